parallel_to_serial_stream: RTL
==============================

PARALLEL_TO_SERIAL_STREAM -- requirements
Module: parallel_to_serial_stream

Interface
REQ-001 Parameter DATA_SIZE, default 64, SHALL set the parallel word width in bits.
REQ-002 Parameter LANES, default 1, SHALL set the serial output width in bits per beat; LANES SHALL divide DATA_SIZE, and violation SHALL be an elaboration error.
REQ-003 Parameter MSB_FIRST, default 1, SHALL select the shift order: 1 = most-significant slice first, 0 = least-significant slice first.
REQ-004 Derived constant BEATS = DATA_SIZE/LANES SHALL be the number of beats per word.
REQ-005 Reset RST SHALL be asynchronous and active-high; clock CLK.
REQ-006 CLK  input  1  rising-edge clock.
REQ-007 RST  input  1  asynchronous active-high reset.
REQ-008 CLEAR  input  1  synchronous discard of all buffered data.
REQ-009 IN_DATA  input  DATA_SIZE  parallel word.
REQ-010 IN_VALID  input  1  IN_DATA is valid.
REQ-011 IN_READY  output  1  block can accept a word.
REQ-012 OUT_DATA  output  LANES  current serial beat.
REQ-013 OUT_VALID  output  1  OUT_DATA is valid.
REQ-014 OUT_READY  input  1  downstream consumes the beat.
REQ-015 OUT_LAST  output  1  current beat is the final beat of its word.
REQ-016 BUSY  output  1  a word is held or is being shifted.

Function
REQ-017 The datapath SHALL contain a one-word holding register (flag HOLD_FULL) feeding a DATA_SIZE-bit shift register (flag SHIFT_ACTIVE) and a beat counter of width clog2(BEATS), minimum 1 bit.
REQ-018 IN_READY SHALL equal !HOLD_FULL && !RST, with no combinational path from OUT_READY or IN_VALID.
REQ-019 An input transfer SHALL occur on a rising edge where IN_VALID && IN_READY; IN_DATA is then captured into the holding register and HOLD_FULL is set.
REQ-020 An output transfer SHALL occur on a rising edge where OUT_VALID && OUT_READY.
REQ-021 OUT_VALID SHALL equal SHIFT_ACTIVE.
REQ-022 OUT_DATA SHALL equal the top LANES bits of the shift register when MSB_FIRST=1, or the bottom LANES bits when MSB_FIRST=0, and SHALL be 0 when OUT_VALID=0.
REQ-023 On each output transfer that is not the final beat, the shift register SHALL shift by LANES toward the output end, zero-fill the vacated end, and increment the beat counter.
REQ-024 OUT_LAST SHALL be 1 exactly when SHIFT_ACTIVE=1 and the beat counter equals BEATS-1.
REQ-025 A reload SHALL occur on an edge where HOLD_FULL=1 and either SHIFT_ACTIVE=0 or an output transfer with OUT_LAST=1 occurs; it copies the holding register into the shift register, clears the beat counter, sets SHIFT_ACTIVE and clears HOLD_FULL.
REQ-026 On an output transfer with OUT_LAST=1 and HOLD_FULL=0, SHIFT_ACTIVE SHALL clear and the beat counter SHALL return to 0.
REQ-027 Latency: a word accepted on edge k SHALL present beat 0 with OUT_VALID=1 after edge k+1 when the shifter is idle.
REQ-028 Back-to-back words with OUT_READY held at 1 SHALL stream with no idle cycle between the final beat of one word and beat 0 of the next.
REQ-029 Stall: while OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_LAST and the beat counter SHALL hold.
REQ-030 If a reload and an input transfer would occur on the same edge, the input SHALL NOT be accepted, because IN_READY was 0 while HOLD_FULL=1; no word SHALL be lost or duplicated.
REQ-031 CLEAR=1 SHALL, on the next edge, clear HOLD_FULL, SHIFT_ACTIVE, the beat counter and the shift register, override any simultaneous input or output transfer, and leave IN_READY=1 afterwards.
REQ-032 BUSY SHALL equal HOLD_FULL || SHIFT_ACTIVE.

Reset
REQ-033 While RST=1: shift register, holding register and beat counter = 0; HOLD_FULL, SHIFT_ACTIVE, OUT_VALID, OUT_LAST, BUSY, IN_READY = 0; OUT_DATA = 0.
REQ-034 RST asserted mid-word SHALL discard all data immediately; after release, IN_READY=1 and OUT_VALID=0 until a new word is accepted.

Verification
REQ-035 DATA_SIZE=8, LANES=1, MSB_FIRST=1, input 0xA5, OUT_READY=1 -> OUT_DATA 1,0,1,0,0,1,0,1 on consecutive cycles; OUT_LAST only on the 8th beat; first beat 1 cycle after acceptance.
REQ-036 DATA_SIZE=8, LANES=2, MSB_FIRST=0, input 0xC6 -> beats 2,1,0,3; BEATS=4.
REQ-037 Two words 0xF0 then 0x0F offered back-to-back (LANES=1) -> 16 contiguous valid beats with no gap; IN_READY drops while the holding register is full.
REQ-038 OUT_READY=0 for 3 cycles at beat 3 of 0xA5 -> OUT_DATA stays 0 and the counter stays 3; the sequence resumes intact.
REQ-039 RST pulsed at beat 4 of 0xA5 -> OUT_VALID=0 and OUT_DATA=0 immediately; the next word 0x3C serializes correctly from beat 0.
REQ-040 CLEAR with HOLD_FULL=1, SHIFT_ACTIVE=1 and IN_VALID=1 -> next cycle BUSY=0 and IN_READY=1, no beats emitted, and the offered word is not captured.

Source files
------------

// File: rtl/parallel_to_serial_stream.sv
// Parallel-to-serial stream converter: a one-word holding register feeds a shift
// register that emits LANES bits per beat under a valid/ready handshake.
module parallel_to_serial_stream #(
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned LANES     = 1,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CLEAR,
   input  logic [DATA_SIZE-1:0] IN_DATA,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   output logic [LANES-1:0]     OUT_DATA,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic                 OUT_LAST,
   output logic                 BUSY
);

   localparam int unsigned BEATS = DATA_SIZE / LANES;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   if ((DATA_SIZE % LANES) != 0) begin : g_bad_lanes
      $error("parallel_to_serial_stream: LANES must divide DATA_SIZE");
   end

   logic [DATA_SIZE-1:0] r_hold_data;
   logic                 r_hold_full;
   logic [DATA_SIZE-1:0] r_shift;
   logic                 r_shift_active;
   logic [CNT_W-1:0]     r_cnt;

   logic                 w_last;
   logic                 w_out_xfer;
   logic                 w_in_xfer;
   logic                 w_reload;
   logic [LANES-1:0]     w_head;
   logic [DATA_SIZE-1:0] w_shift_next;

   // Output end of the shift register and the shift toward it.
   if (MSB_FIRST != 0) begin : g_msb
      assign w_head       = r_shift[DATA_SIZE-1 -: LANES];
      assign w_shift_next = r_shift << LANES;
   end else begin : g_lsb
      assign w_head       = r_shift[LANES-1:0];
      assign w_shift_next = r_shift >> LANES;
   end

   assign w_last     = r_shift_active && (r_cnt == LAST_CNT);
   assign w_out_xfer = r_shift_active && OUT_READY;
   assign w_in_xfer  = IN_VALID && !r_hold_full;
   assign w_reload   = r_hold_full && (!r_shift_active || (w_out_xfer && w_last));

   assign IN_READY  = !r_hold_full && !RST;
   assign OUT_VALID = r_shift_active;
   assign OUT_DATA  = r_shift_active ? w_head : '0;
   assign OUT_LAST  = w_last;
   assign BUSY      = r_hold_full || r_shift_active;

   // Holding register: filled by an input transfer, emptied by a reload.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_hold_data <= '0;
         r_hold_full <= 1'b0;
      end else if (CLEAR) begin
         r_hold_data <= '0;
         r_hold_full <= 1'b0;
      end else if (w_reload) begin
         r_hold_full <= 1'b0;
      end else if (w_in_xfer) begin
         r_hold_data <= IN_DATA;
         r_hold_full <= 1'b1;
      end
   end

   // Shifter and beat counter; a reload on the final beat keeps the stream gapless.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_shift        <= '0;
         r_shift_active <= 1'b0;
         r_cnt          <= '0;
      end else if (CLEAR) begin
         r_shift        <= '0;
         r_shift_active <= 1'b0;
         r_cnt          <= '0;
      end else if (w_reload) begin
         r_shift        <= r_hold_data;
         r_shift_active <= 1'b1;
         r_cnt          <= '0;
      end else if (w_out_xfer) begin
         if (w_last) begin
            r_shift        <= '0;
            r_shift_active <= 1'b0;
            r_cnt          <= '0;
         end else begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule
